// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // Byte lanes within a 32-bit word, little-endian.
    localparam logic [1:0] LANE_0 = 2'd0;  // bits [7:0]
    localparam logic [1:0] LANE_1 = 2'd1;  // bits [15:8]
    localparam logic [1:0] LANE_2 = 2'd2;  // bits [23:16]
    localparam logic [1:0] LANE_3 = 2'd3;  // bits [31:24]

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W           = 8;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/acknowledge data-memory port between the MEM stage and memory.
interface mem_stage_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_stage_ctrl_sb_merge.sv
// Replaces one byte lane of a 32-bit word; used for read-modify-write byte stores.
module sb_merge
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [7:0]  data_byte,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Overwrite the selected lane, keep the other three bytes.
    always_comb begin
        merged = word;
        case (lane)
            LANE_0:  merged[7:0]   = data_byte;
            LANE_1:  merged[15:8]  = data_byte;
            LANE_2:  merged[23:16] = data_byte;
            LANE_3:  merged[31:24] = data_byte;
            default: merged        = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: word loads, word stores and read-modify-write byte
// stores over a req/ack memory port, with pipeline stall and timeout handling.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mtrin,
    input  logic              mwin,
    input  logic              sbin,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       wdata_in,
    output logic              stall,
    mem_stage_ctrl_if.master  mem,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic             rmw;
    logic [1:0]       lane;
    logic [7:0]       byte_q;
    logic [CNT_W-1:0] cnt;
    logic             tmo_hit;
    logic [31:0]      merged;

    sb_merge u_merge (
        .word      (mem.mem_rdata),
        .data_byte (byte_q),
        .lane      (lane),
        .merged    (merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall; stall drops only in the cycle an access completes.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        tmo_hit    = (state != IDLE) && !mem.mem_ack && (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                stall = mtrin | mwin;
                if (mtrin || mwin) begin
                    state_next = (mtrin || sbin) ? RD : WR;
                end
            end
            RD: begin
                stall = 1'b1;
                if (mem.mem_ack) begin
                    if (rmw) begin
                        state_next = WR;
                    end else begin
                        state_next = IDLE;
                        stall      = 1'b0;
                    end
                end else if (tmo_hit) begin
                    state_next = IDLE;
                    stall      = 1'b0;
                end
            end
            WR: begin
                stall = 1'b1;
                if (mem.mem_ack || tmo_hit) begin
                    state_next = IDLE;
                    stall      = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus, timeout counter, load result and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            ld_data       <= '0;
            ld_valid      <= 1'b0;
            err           <= 1'b0;
            cnt           <= '0;
            rmw           <= 1'b0;
            lane          <= '0;
            byte_q        <= '0;
        end else begin
            ld_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mtrin || mwin) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_addr <= {addr_in[ADDR_W-1:2], 2'b00};
                        cnt          <= '0;
                        if (mtrin) begin
                            // A load wins over a simultaneous store, which is flagged.
                            mem.mem_we <= 1'b0;
                            rmw        <= 1'b0;
                            if (mwin) begin
                                err <= 1'b1;
                            end
                        end else if (sbin) begin
                            mem.mem_we <= 1'b0;
                            rmw        <= 1'b1;
                            lane       <= addr_in[1:0];
                            byte_q     <= wdata_in[7:0];
                        end else begin
                            mem.mem_we    <= 1'b1;
                            mem.mem_wdata <= wdata_in;
                            rmw           <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (mem.mem_ack) begin
                        if (rmw) begin
                            // Read half of a byte store: request stays up for the write.
                            mem.mem_we    <= 1'b1;
                            mem.mem_wdata <= merged;
                            cnt           <= '0;
                        end else begin
                            mem.mem_req <= 1'b0;
                            ld_data     <= mem.mem_rdata;
                            ld_valid    <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        mem.mem_req <= 1'b0;
                        err         <= 1'b1;
                        if (!rmw) begin
                            ld_data  <= '0;
                            ld_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                    end else if (tmo_hit) begin
                        mem.mem_req <= 1'b0;
                        err         <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: mem.mem_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, multi-cycle
// corner sequences and randomized accesses checked against a reference model.
module tb_mem_stage_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        mtrin;
    logic        mwin;
    logic        sbin;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_stage_ctrl_if #(.ADDR_W(32)) bus ();

    mem_stage_ctrl #(
        .ADDR_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mtrin    (mtrin),
        .mwin     (mwin),
        .sbin     (sbin),
        .addr_in  (addr_in),
        .wdata_in (wdata_in),
        .stall    (stall),
        .mem      (bus),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the most recent run of request-low cycles before a request.
    int unsigned req_low_run = 0;
    int unsigned last_gap    = 0;
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (req_low_run > 0) last_gap = req_low_run;
            req_low_run = 0;
        end else begin
            req_low_run = req_low_run + 1;
        end
    end

    typedef struct {
        logic        mtr;
        logic        mw;
        logic        sb;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdat;
        int unsigned rd_dly;   // idle cycles before ack; >= TMO means never
        int unsigned wr_dly;
        int unsigned ex_stall; // cycles with stall high
        logic [31:0] ex_addr;
        logic        ex_rd;    // a read phase is expected
        logic        ex_wr;    // a write phase is expected
        logic [31:0] ex_wdata;
        logic        ex_ldv;
        logic [31:0] ex_ld;
        logic        ex_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: outcome of one instruction from the access rules.
    function automatic vec_t model(input vec_t v, input logic err_in);
        vec_t        r;
        logic        rd_ok;
        logic        wr_ok;
        int unsigned lenr;
        int unsigned lenw;
        int unsigned sh;
        logic [31:0] mask;
        r = v;
        rd_ok = (v.rd_dly < TMO);
        wr_ok = (v.wr_dly < TMO);
        lenr  = rd_ok ? v.rd_dly + 1 : TMO;
        lenw  = wr_ok ? v.wr_dly + 1 : TMO;
        r.ex_addr  = v.addr & 32'hFFFF_FFFC;
        r.ex_rd    = 1'b0;
        r.ex_wr    = 1'b0;
        r.ex_wdata = '0;
        r.ex_ldv   = 1'b0;
        r.ex_ld    = '0;
        r.ex_stall = 0;
        r.ex_err   = err_in;
        if (v.mtr) begin
            r.ex_rd    = 1'b1;
            r.ex_stall = lenr;
            r.ex_ldv   = 1'b1;
            r.ex_ld    = rd_ok ? v.rdat : 32'd0;
            if (v.mw || !rd_ok) r.ex_err = 1'b1;
        end else if (v.mw && v.sb) begin
            r.ex_rd = 1'b1;
            if (rd_ok) begin
                sh         = 8 * int'(v.addr % 4);
                mask       = 32'h0000_00FF << sh;
                r.ex_wr    = 1'b1;
                r.ex_wdata = (v.rdat & ~mask) | ({24'd0, v.wd[7:0]} << sh);
                r.ex_stall = lenr + lenw;
                if (!wr_ok) r.ex_err = 1'b1;
            end else begin
                r.ex_stall = lenr;
                r.ex_err   = 1'b1;
            end
        end else if (v.mw) begin
            r.ex_wr    = 1'b1;
            r.ex_wdata = v.wd;
            r.ex_stall = lenw;
            if (!wr_ok) r.ex_err = 1'b1;
        end
        return r;
    endfunction

    // Present one EX/MEM instruction, act as the memory, then check results.
    task automatic run_op(input vec_t v, input string tag);
        int unsigned st_hi;
        int unsigned dly;
        logic        bad;
        logic        lv_bad;
        logic        exp_we;
        @(negedge clk);
        mtrin       = v.mtr;
        mwin        = v.mw;
        sbin        = v.sb;
        addr_in     = v.addr;
        wdata_in    = v.wd;
        bus.mem_ack = 1'b0;
        #1;
        st_hi  = (stall === 1'b1) ? 1 : 0;
        lv_bad = 1'b0;
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if (p == 0 && !v.ex_rd) continue;
            if (p == 1 && !v.ex_wr) continue;
            dly    = (p == 0) ? v.rd_dly : v.wr_dly;
            exp_we = (p == 1);
            bad    = 1'b0;
            for (int unsigned k = 0; k < TMO; k++) begin
                @(negedge clk);
                if (bus.mem_req !== 1'b1 || bus.mem_we !== exp_we || bus.mem_addr !== v.ex_addr) bad = 1'b1;
                if (p == 1 && bus.mem_wdata !== v.ex_wdata) bad = 1'b1;
                if (ld_valid !== 1'b0) lv_bad = 1'b1;
                bus.mem_ack   = (k == dly);
                bus.mem_rdata = (k == dly) ? v.rdat : $urandom();
                #1;
                if (stall === 1'b1) st_hi++;
                @(posedge clk);
                if (k == dly) break;
            end
            check($sformatf("%s/bus_phase%0d_bad", tag, p), {31'd0, bad}, 32'd0);
        end
        #1;
        mtrin       = 1'b0;
        mwin        = 1'b0;
        sbin        = 1'b0;
        bus.mem_ack = 1'b0;
        check($sformatf("%s/stall_cycles", tag), st_hi, v.ex_stall);
        check($sformatf("%s/ld_valid_early", tag), {31'd0, lv_bad}, 32'd0);
        check($sformatf("%s/ld_valid", tag), {31'd0, ld_valid}, {31'd0, v.ex_ldv});
        if (v.ex_ldv) check($sformatf("%s/ld_data", tag), ld_data, v.ex_ld);
        check($sformatf("%s/err", tag), {31'd0, err}, {31'd0, v.ex_err});
        check($sformatf("%s/req_dropped", tag), {31'd0, bus.mem_req}, 32'd0);
    endtask

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t w;
        logic m_err;
        int unsigned kind;

        //           mtr   mw    sb    addr          wd            rdat          rd wr st ex_addr       rd    wr    ex_wdata      ldv   ex_ld         err
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1, 0, 2, 32'h0000_1004, 1'b1, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_2003, 32'h1234_5678, 32'h0,        0, 0, 1, 32'h0000_2000, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_3002, 32'h0000_00AB, 32'h1122_3344, 0, 1, 3, 32'h0000_3000, 1'b1, 1'b1, 32'h11AB_3344, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'hFFFF_FF5A, 32'hCAFE_BABE, 2, 0, 4, 32'h0000_4000, 1'b1, 1'b1, 32'hCAFE_BA5A, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_4007, 32'h0000_0077, 32'h0102_0304, 0, 2, 4, 32'h0000_4004, 1'b1, 1'b1, 32'h7702_0304, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h0000_5001, 32'h0000_009C, 32'h0,        0, 0, 2, 32'h0000_5000, 1'b1, 1'b1, 32'h0000_9C00, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_6008, 32'h0,        32'h0BAD_F00D, 3, 0, 4, 32'h0000_6008, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0BAD_F00D, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_700C, 32'hA5A5_A5A5, 32'h0,        0, 3, 4, 32'h0000_700C, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0000_7777, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_8000, 32'h0,        32'h0,        9, 0, 4, 32'h0000_8000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_8004, 32'h0,        32'h1357_9BDF, 0, 0, 1, 32'h0000_8004, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1357_9BDF, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h0000_8802, 32'h0000_00EE, 32'h0,        9, 0, 4, 32'h0000_8800, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0000_8C00, 32'h0F0F_0F0F, 32'h0,        0, 9, 4, 32'h0000_8C00, 1'b0, 1'b1, 32'h0F0F_0F0F, 1'b0, 32'h0,        1'b1};

        rst           = 1'b1;
        mtrin         = 1'b0;
        mwin          = 1'b0;
        sbin          = 1'b0;
        addr_in       = '0;
        wdata_in      = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/stall", {31'd0, stall}, 32'd0);
        check("reset/mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("reset/mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("reset/mem_addr", bus.mem_addr, 32'd0);
        check("reset/mem_wdata", bus.mem_wdata, 32'd0);
        check("reset/ld_data", ld_data, 32'd0);
        check("reset/ld_valid", {31'd0, ld_valid}, 32'd0);
        check("reset/err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset during a write phase abandons the access; a stray ack is ignored.
        @(negedge clk);
        mwin     = 1'b1;
        sbin     = 1'b0;
        addr_in  = 32'h0000_A000;
        wdata_in = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        check("rstwr/req_before", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        rst  = 1'b1;
        mwin = 1'b0;
        @(posedge clk);
        #1;
        check("rstwr/mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rstwr/stall", {31'd0, stall}, 32'd0);
        check("rstwr/err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        check("stray_ack/mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("stray_ack/ld_valid", {31'd0, ld_valid}, 32'd0);
        check("stray_ack/ld_data", ld_data, 32'd0);
        check("stray_ack/err", {31'd0, err}, 32'd0);
        check("stray_ack/stall", {31'd0, stall}, 32'd0);
        m_err = 1'b0;

        // Load then store back to back, one ack-delay cycle each.
        v        = '{1'b1, 1'b0, 1'b0, 32'h0000_B000, 32'h0, 32'h2468_ACE0, 1, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        w        = model(v, m_err);
        m_err    = w.ex_err;
        run_op(w, "b2b_load");
        v        = '{1'b0, 1'b1, 1'b0, 32'h0000_B104, 32'h1357_2468, 32'h0, 0, 1, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        w        = model(v, m_err);
        m_err    = w.ex_err;
        run_op(w, "b2b_store");
        check("b2b/idle_gap", last_gap, 32'd1);

        // Load and store together: the load proceeds and err is raised.
        v        = '{1'b1, 1'b1, 1'b0, 32'h0000_9001, 32'h7777_7777, 32'h55AA_55AA, 0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        w        = model(v, m_err);
        m_err    = w.ex_err;
        run_op(w, "illegal");

        for (int i = 0; i < 60; i++) begin
            kind     = $urandom_range(0, 3);
            v        = tbl[0];
            v.mtr    = (kind == 1);
            v.mw     = (kind >= 2);
            v.sb     = (kind == 3) || (kind == 0 && $urandom_range(0, 1) == 1);
            v.addr   = $urandom();
            v.wd     = $urandom();
            v.rdat   = $urandom();
            v.rd_dly = $urandom_range(0, TMO + 1);
            v.wr_dly = $urandom_range(0, TMO + 1);
            w        = model(v, m_err);
            m_err    = w.ex_err;
            run_op(w, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
